// File: rtl/lane_reconfig_sequencer.sv
// lane_reconfig_sequencer: drains the pipeline, then power-sequences dispatch lanes to a new active mask.
// Define LANE_RECONFIG_DRAIN_TIMEOUT_EN to abort a request that cannot drain within DRAIN_TIMEOUT cycles.
module lane_reconfig_sequencer #(
   parameter int DISPATCH_WIDTH = 4,
   parameter int DRAIN_CYCLES = 2,
   parameter int SETTLE_CYCLES = 4,
   parameter int DRAIN_TIMEOUT = 256
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cfgReq_i,
   input  logic [DISPATCH_WIDTH-1:0] cfgMask_i,
   input  logic                      pipeEmpty_i,
   output logic                      stallFetch_o,
   output logic [DISPATCH_WIDTH-1:0] laneActive_o,
   output logic [DISPATCH_WIDTH-1:0] pwrEn_o,
   output logic                      busy_o,
   output logic                      cfgAck_o,
   output logic                      cfgErr_o
);
   typedef enum logic [2:0] {IDLE, DRAIN, PWR_UP, SETTLE, SWITCH, DONE} state_t;
   localparam logic [3:0] DRAIN_N = 4'(DRAIN_CYCLES);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   state_t state_q, state_d;
   logic [DISPATCH_WIDTH-1:0] mask_q, mask_d, act_q, act_d, pwr_q, pwr_d;
   logic [3:0] dcnt_q, dcnt_d, scnt_q, scnt_d, dcnt_inc;
   logic stall_q, stall_d, busy_q, busy_d, ack_q, ack_d, err_q, err_d;
   logic timeout_hit;
   assign dcnt_inc = pipeEmpty_i ? (dcnt_q == 4'hF ? dcnt_q : dcnt_q + 4'd1) : 4'd0;
`ifdef LANE_RECONFIG_DRAIN_TIMEOUT_EN
   localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(DRAIN_TIMEOUT - 1);
   logic [TW-1:0] tcnt_q, tcnt_d;
   // Residence counter idles at zero outside DRAIN, so it is clear on every entry.
   assign tcnt_d = (state_q != DRAIN) ? '0 : (tcnt_q == TO_LAST ? tcnt_q : tcnt_q + 1'b1);
   assign timeout_hit = (state_q == DRAIN) && (tcnt_q == TO_LAST);
   always_ff @(posedge clk) begin
      if (reset) tcnt_q <= '0;
      else tcnt_q <= tcnt_d;
   end
`else
   localparam int unused_timeout = DRAIN_TIMEOUT;
   assign timeout_hit = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      mask_d = mask_q;
      act_d = act_q;
      pwr_d = pwr_q;
      dcnt_d = dcnt_q;
      scnt_d = scnt_q;
      stall_d = stall_q;
      ack_d = 1'b0;
      err_d = 1'b0;
      unique case (state_q)
         IDLE: if (cfgReq_i) begin
            if (!cfgMask_i[0]) err_d = 1'b1;
            else if (cfgMask_i == act_q) state_d = DONE;
            else begin
               mask_d = cfgMask_i;
               dcnt_d = 4'd0;
               stall_d = 1'b1;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc >= DRAIN_N) state_d = PWR_UP;
            else if (timeout_hit) begin
               state_d = IDLE;
               err_d = 1'b1;
               stall_d = 1'b0;
            end
         end
         PWR_UP: begin
            // Power added lanes and isolate removed ones before anything powers down.
            pwr_d = pwr_q | mask_q;
            act_d = act_q & mask_q;
            scnt_d = 4'd0;
            state_d = SETTLE;
         end
         SETTLE: begin
            scnt_d = scnt_q == 4'hF ? scnt_q : scnt_q + 4'd1;
            if (scnt_q >= SETTLE_LAST) state_d = SWITCH;
         end
         SWITCH: begin
            act_d = mask_q;
            pwr_d = mask_q;
            state_d = DONE;
         end
         DONE: begin
            ack_d = 1'b1;
            stall_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mask_q <= '1;
         act_q <= '1;
         pwr_q <= '1;
         dcnt_q <= 4'd0;
         scnt_q <= 4'd0;
         stall_q <= 1'b0;
         busy_q <= 1'b0;
         ack_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q <= mask_d;
         act_q <= act_d;
         pwr_q <= pwr_d;
         dcnt_q <= dcnt_d;
         scnt_q <= scnt_d;
         stall_q <= stall_d;
         busy_q <= busy_d;
         ack_q <= ack_d;
         err_q <= err_d;
      end
   end
   assign stallFetch_o = stall_q;
   assign laneActive_o = act_q;
   assign pwrEn_o = pwr_q;
   assign busy_o = busy_q;
   assign cfgAck_o = ack_q;
   assign cfgErr_o = err_q;
endmodule

// File: tb/tb_lane_reconfig_sequencer.sv
// tb_lane_reconfig_sequencer: directed and random checks against a timeline model of the lane sequencer.
module tb_lane_reconfig_sequencer;
   localparam int D = 2;
   localparam int S = 4;
   localparam int TO = 8;
   logic clk = 1'b0, rst = 1'b1, req = 1'b0, pe = 1'b1;
   logic [3:0] mask = 4'd0;
   logic stall, busy, ack, err;
   logic [3:0] act, pwr;
   int checks = 0, errors = 0;
   logic [3:0] m_act, m_pwr, m_tgt;
   logic m_stall, m_busy, m_ack, m_err, draining;
   int run, k, dt;

   lane_reconfig_sequencer #(.DISPATCH_WIDTH(4), .DRAIN_CYCLES(D), .SETTLE_CYCLES(S), .DRAIN_TIMEOUT(TO)) dut (
      .clk(clk), .reset(rst), .cfgReq_i(req), .cfgMask_i(mask), .pipeEmpty_i(pe),
      .stallFetch_o(stall), .laneActive_o(act), .pwrEn_o(pwr), .busy_o(busy),
      .cfgAck_o(ack), .cfgErr_o(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: an accepted request drains, then follows a fixed timeline counted from the drain edge.
   initial forever begin
      @(posedge clk);
      m_ack = 1'b0;
      m_err = 1'b0;
      if (rst) begin
         m_act = 4'hF; m_pwr = 4'hF; m_tgt = 4'hF;
         m_stall = 1'b0; m_busy = 1'b0; draining = 1'b0; run = 0; k = 0; dt = 0;
      end else if (!m_busy) begin
         if (req) begin
            if (mask == 4'd0 || !mask[0]) m_err = 1'b1;
            else begin
               m_busy = 1'b1;
               m_tgt = mask;
               if (mask == m_act) begin draining = 1'b0; k = S + 2; end
               else begin m_stall = 1'b1; draining = 1'b1; run = 0; dt = 0; end
            end
         end
      end else if (draining) begin
         run = pe ? run + 1 : 0;
         dt++;
         if (run >= D) begin draining = 1'b0; k = 0; end
`ifdef LANE_RECONFIG_DRAIN_TIMEOUT_EN
         else if (dt >= TO) begin draining = 1'b0; m_busy = 1'b0; m_stall = 1'b0; m_err = 1'b1; end
`endif
      end else begin
         k++;
         if (k == 1) begin m_pwr = m_pwr | m_tgt; m_act = m_act & m_tgt; end
         if (k == S + 2) begin m_act = m_tgt; m_pwr = m_tgt; end
         if (k == S + 3) begin m_ack = 1'b1; m_stall = 1'b0; m_busy = 1'b0; end
      end
   end

   initial forever begin
      @(negedge clk);
      chk("outputs{stall,busy,ack,err,act,pwr}", {4'd0, stall, busy, ack, err, act, pwr},
          {4'd0, m_stall, m_busy, m_ack, m_err, m_act, m_pwr});
      chk("act_without_pwr", {12'd0, act & ~pwr}, 16'd0);
   end

   initial begin
      step(2);
      chk("reset_act", {12'd0, act}, 16'hF);
      chk("reset_pwr", {12'd0, pwr}, 16'hF);
      chk("reset_flags", {12'd0, stall, busy, ack, err}, 16'd0);
      rst = 1'b0;
      step(1); req = 1'b1; mask = 4'b0011;
      step(1); req = 1'b0; chk("shrink_stall", {15'd0, stall}, 16'd1);
      step(3); chk("shrink_isolate", {8'd0, act, pwr}, 16'h3F);
      step(4); chk("shrink_settle_pwr", {12'd0, pwr}, 16'hF);
      step(1); chk("shrink_switch", {8'd0, act, pwr}, 16'h33);
      step(1); chk("shrink_ack", {14'd0, ack, stall}, 16'b10);
      step(1); chk("shrink_ack_once", {15'd0, ack}, 16'd0);
      req = 1'b1; mask = 4'b0111;
      step(1); req = 1'b0;
      step(3); chk("grow_pwr_first", {8'd0, act, pwr}, 16'h37);
      step(5); chk("grow_switch", {12'd0, act}, 16'h7);
      step(1); chk("grow_ack", {15'd0, ack}, 16'd1);
      req = 1'b1; mask = 4'b0010;
      step(1); req = 1'b0; chk("invalid_0010", {7'd0, err, act, pwr}, 16'h177);
      step(1); chk("invalid_pulse", {15'd0, err}, 16'd0);
      req = 1'b1; mask = 4'b0000;
      step(1); req = 1'b0; chk("invalid_0000", {7'd0, err, act, pwr}, 16'h177);
      step(1);
      req = 1'b1; mask = 4'b0111;
      step(1); req = 1'b0; chk("same_busy", {14'd0, busy, stall}, 16'b10);
      step(1); chk("same_ack", {14'd0, ack, stall}, 16'b10);
      req = 1'b1; mask = 4'b0011; pe = 1'b0;
      step(1); req = 1'b0; pe = 1'b1; chk("restart_stall", {15'd0, stall}, 16'd1);
      step(1); pe = 1'b0;
      step(1); pe = 1'b1;
      step(1);
      step(1); chk("restart_not_yet", {11'd0, stall, act}, 16'h17);
      step(1); chk("restart_pwrup", {11'd0, stall, act}, 16'h13);
      step(6);
`ifdef LANE_RECONFIG_DRAIN_TIMEOUT_EN
      req = 1'b1; mask = 4'b0111; pe = 1'b0;
      step(1); req = 1'b0;
      step(8); chk("timeout_abort", {4'd0, err, busy, stall, 1'b0, act, pwr}, 16'h0833);
      pe = 1'b1;
`endif
      for (int i = 0; i < 3000; i++) begin
         step(1);
         rst = $urandom_range(0, 299) == 0;
         req = $urandom_range(0, 2) == 0;
         mask = 4'($urandom_range(0, 15));
         pe = $urandom_range(0, 3) != 0;
      end
      step(1); rst = 1'b0; req = 1'b0;
      step(30);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
